// File: rtl/lsu_bus_master_if.sv
// BusEntry: single-transaction memory/peripheral bus.
//   clk          shared bus clock
//   req          initiator request strobe, one cycle per transaction
//   we           1 = write, 0 = read
//   be[3:0]      byte enables within the addressed word
//   addr[31:0]   word-aligned byte address
//   wdata[31:0]  write data, already placed in the enabled byte lanes
//   rdata[31:0]  read data from the responder, valid with ack
//   ack          responder completion strobe
interface BusEntry (
    input logic clk
);
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ack;

    modport Master (
        input  clk,
        input  rdata,
        input  ack,
        output req,
        output we,
        output be,
        output addr,
        output wdata
    );

    modport Slave (
        input  clk,
        input  req,
        input  we,
        input  be,
        input  addr,
        input  wdata,
        output rdata,
        output ack
    );
endinterface

// File: rtl/lsu_bus_master.sv
// lsu_bus_master: load/store unit bus initiator.
// Converts RV32I LB/LH/LW/LBU/LHU/SB/SH/SW requests into single BusEntry
// transactions, stalls the core until the responder acks, and returns the
// aligned, extended load data in the completion cycle.
//   clk_i          clock (same as bus.clk)
//   rst_i          synchronous active-high reset
//   lsu_req_i      core access request, held while lsu_stall_o is high
//   lsu_we_i       1 = store, 0 = load
//   lsu_size_i     funct3 access size (B/H/W/BU/HU)
//   lsu_addr_i     byte address
//   lsu_wdata_i    store data, LSB-aligned
//   lsu_rdata_o    load result, valid only in the completion cycle
//   lsu_stall_o    core must hold its request
//   lsu_illegal_o  misaligned or illegal-size request (pulse)
//   lsu_timeout_o  transaction aborted without ack (pulse)
//   bus            BusEntry master port
module lsu_bus_master #(
    parameter int unsigned ACK_TIMEOUT = 16
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          lsu_req_i,
    input  logic          lsu_we_i,
    input  logic [2:0]    lsu_size_i,
    input  logic [31:0]   lsu_addr_i,
    input  logic [31:0]   lsu_wdata_i,
    output logic [31:0]   lsu_rdata_o,
    output logic          lsu_stall_o,
    output logic          lsu_illegal_o,
    output logic          lsu_timeout_o,
    BusEntry.Master       bus
);

    localparam int unsigned CW = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(ACK_TIMEOUT - 1);

    typedef enum logic {
        IDLE,
        WAIT
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [2:0]     size_q;
    logic [1:0]     off_q;

    logic           legal;
    logic           start;
    logic [3:0]     be_d;
    logic [31:0]    wdata_d;
    logic [31:0]    shifted;
    logic [31:0]    load_data;

    // Request decode: legality, byte enables and lane-replicated store data.
    always_comb begin
        legal   = 1'b0;
        be_d    = 4'b1111;
        wdata_d = lsu_wdata_i;
        case (lsu_size_i)
            3'b000, 3'b100: legal = 1'b1;
            3'b001, 3'b101: legal = ~lsu_addr_i[0];
            3'b010:         legal = (lsu_addr_i[1:0] == 2'b00);
            default:        legal = 1'b0;
        endcase
        case (lsu_size_i[1:0])
            2'b00: begin
                be_d    = 4'b0001 << lsu_addr_i[1:0];
                wdata_d = {4{lsu_wdata_i[7:0]}};
            end
            2'b01: begin
                be_d    = 4'b0011 << {lsu_addr_i[1], 1'b0};
                wdata_d = {2{lsu_wdata_i[15:0]}};
            end
            default: begin
                be_d    = 4'b1111;
                wdata_d = lsu_wdata_i;
            end
        endcase
    end

    // Load extraction from the responder's word using the latched offset/size.
    always_comb begin
        shifted   = bus.rdata >> {off_q, 3'b000};
        load_data = shifted;
        case (size_q)
            3'b000:  load_data = {{24{shifted[7]}},  shifted[7:0]};
            3'b001:  load_data = {{16{shifted[15]}}, shifted[15:0]};
            3'b100:  load_data = {24'h000000, shifted[7:0]};
            3'b101:  load_data = {16'h0000,   shifted[15:0]};
            default: load_data = shifted;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        start         = 1'b0;
        lsu_stall_o   = 1'b0;
        lsu_illegal_o = 1'b0;
        lsu_timeout_o = 1'b0;
        lsu_rdata_o   = '0;
        case (state_q)
            IDLE: begin
                if (lsu_req_i) begin
                    if (legal) begin
                        start       = 1'b1;
                        lsu_stall_o = 1'b1;
                        cnt_d       = '0;
                        state_d     = WAIT;
                    end else begin
                        lsu_illegal_o = 1'b1;
                    end
                end
            end
            WAIT: begin
                // ack takes priority over the timeout on the same cycle
                if (bus.ack) begin
                    lsu_rdata_o = bus.we ? '0 : load_data;
                    state_d     = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    lsu_timeout_o = 1'b1;
                    state_d       = IDLE;
                end else begin
                    lsu_stall_o = 1'b1;
                    cnt_d       = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        // Reset masks every core-facing output, including a late ack.
        if (rst_i) begin
            lsu_stall_o   = 1'b0;
            lsu_illegal_o = 1'b0;
            lsu_timeout_o = 1'b0;
            lsu_rdata_o   = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            size_q    <= '0;
            off_q     <= '0;
            bus.req   <= 1'b0;
            bus.we    <= 1'b0;
            bus.be    <= '0;
            bus.addr  <= '0;
            bus.wdata <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            // req is a one-cycle strobe; address/data hold until the next start
            bus.req <= start;
            if (start) begin
                size_q    <= lsu_size_i;
                off_q     <= lsu_addr_i[1:0];
                bus.we    <= lsu_we_i;
                bus.be    <= be_d;
                bus.addr  <= {lsu_addr_i[31:2], 2'b00};
                bus.wdata <= wdata_d;
            end
        end
    end

endmodule

// File: tb/tb_lsu_bus_master.sv
module tb_lsu_bus_master;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        lsu_req = 1'b0;
    logic        lsu_we = 1'b0;
    logic [2:0]  lsu_size = 3'b000;
    logic [31:0] lsu_addr = '0;
    logic [31:0] lsu_wdata = '0;
    logic [31:0] lsu_rdata;
    logic        lsu_stall;
    logic        lsu_illegal;
    logic        lsu_timeout;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    always #5 clk = ~clk;

    BusEntry bus_if (.clk(clk));

    lsu_bus_master #(.ACK_TIMEOUT(16)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .lsu_req_i     (lsu_req),
        .lsu_we_i      (lsu_we),
        .lsu_size_i    (lsu_size),
        .lsu_addr_i    (lsu_addr),
        .lsu_wdata_i   (lsu_wdata),
        .lsu_rdata_o   (lsu_rdata),
        .lsu_stall_o   (lsu_stall),
        .lsu_illegal_o (lsu_illegal),
        .lsu_timeout_o (lsu_timeout),
        .bus           (bus_if.Master)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock cycle: inputs applied at the falling edge, outputs settle 1 time unit later.
    task automatic cyc(input logic rs, input logic r, input logic we, input logic [2:0] sz,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic ak, input logic [31:0] rd);
        @(negedge clk);
        rst          = rs;
        lsu_req      = r;
        lsu_we       = we;
        lsu_size     = sz;
        lsu_addr     = a;
        lsu_wdata    = wd;
        bus_if.ack   = ak;
        bus_if.rdata = rd;
        #1;
    endtask

    initial begin
        bus_if.ack   = 1'b0;
        bus_if.rdata = '0;

        // Reset: stall forced low even with a legal request present
        cyc(1, 1, 0, 3'b010, 32'h0, 32'h0, 0, 32'h0);
        check("rst_stall", lsu_stall, 0);
        check("rst_req", bus_if.req, 0);
        check("rst_be", bus_if.be, 0);
        check("rst_addr", bus_if.addr, 0);
        check("rst_wdata", bus_if.wdata, 0);
        check("rst_rdata", lsu_rdata, 0);
        check("rst_illegal", lsu_illegal, 0);
        check("rst_timeout", lsu_timeout, 0);
        cyc(0, 0, 0, 3'b000, 32'h0, 32'h0, 0, 32'h0);
        check("idle_stall", lsu_stall, 0);

        // SW 0xDEADBEEF @0x100
        cyc(0, 1, 1, 3'b010, 32'h100, 32'hDEADBEEF, 0, 32'h0);
        check("sw_c0_stall", lsu_stall, 1);
        check("sw_c0_req", bus_if.req, 0);
        cyc(0, 1, 1, 3'b010, 32'h100, 32'hDEADBEEF, 0, 32'h0);
        check("sw_c1_stall", lsu_stall, 1);
        check("sw_c1_req", bus_if.req, 1);
        check("sw_be", bus_if.be, 4'b1111);
        check("sw_addr", bus_if.addr, 32'h100);
        check("sw_wdata", bus_if.wdata, 32'hDEADBEEF);
        check("sw_we", bus_if.we, 1);
        cyc(0, 1, 1, 3'b010, 32'h100, 32'hDEADBEEF, 1, 32'h0);
        check("sw_c2_stall", lsu_stall, 0);
        check("sw_c2_rdata", lsu_rdata, 0);
        check("sw_c2_req", bus_if.req, 0);

        // LW @0x100
        cyc(0, 1, 0, 3'b010, 32'h100, 32'h0, 0, 32'h0);
        check("lw_c0_stall", lsu_stall, 1);
        cyc(0, 1, 0, 3'b010, 32'h100, 32'h0, 0, 32'h0);
        check("lw_c1_req", bus_if.req, 1);
        check("lw_c1_we", bus_if.we, 0);
        check("lw_c1_stall", lsu_stall, 1);
        cyc(0, 1, 0, 3'b010, 32'h100, 32'h0, 1, 32'hDEADBEEF);
        check("lw_c2_stall", lsu_stall, 0);
        check("lw_c2_rdata", lsu_rdata, 32'hDEADBEEF);
        cyc(0, 0, 0, 3'b000, 32'h0, 32'h0, 0, 32'hDEADBEEF);
        check("lw_after_rdata", lsu_rdata, 0);
        check("lw_after_stall", lsu_stall, 0);

        // SB 0x80 @0x103
        cyc(0, 1, 1, 3'b000, 32'h103, 32'h00000080, 0, 32'h0);
        cyc(0, 1, 1, 3'b000, 32'h103, 32'h00000080, 0, 32'h0);
        check("sb_be", bus_if.be, 4'b1000);
        check("sb_wdata", bus_if.wdata, 32'h80808080);
        check("sb_addr", bus_if.addr, 32'h100);
        cyc(0, 1, 1, 3'b000, 32'h103, 32'h00000080, 1, 32'h0);
        check("sb_done_stall", lsu_stall, 0);

        // Word at 0x100 now 0x80ADBEEF: LB/LBU @0x103, LH/LHU @0x102
        cyc(0, 1, 0, 3'b000, 32'h103, 32'h0, 0, 32'h0);
        cyc(0, 1, 0, 3'b000, 32'h103, 32'h0, 0, 32'h0);
        check("lb_be", bus_if.be, 4'b1000);
        cyc(0, 1, 0, 3'b000, 32'h103, 32'h0, 1, 32'h80ADBEEF);
        check("lb_rdata", lsu_rdata, 32'hFFFFFF80);
        cyc(0, 1, 0, 3'b100, 32'h103, 32'h0, 0, 32'h0);
        cyc(0, 1, 0, 3'b100, 32'h103, 32'h0, 0, 32'h0);
        cyc(0, 1, 0, 3'b100, 32'h103, 32'h0, 1, 32'h80ADBEEF);
        check("lbu_rdata", lsu_rdata, 32'h00000080);
        cyc(0, 1, 0, 3'b001, 32'h102, 32'h0, 0, 32'h0);
        cyc(0, 1, 0, 3'b001, 32'h102, 32'h0, 0, 32'h0);
        check("lh_be", bus_if.be, 4'b1100);
        cyc(0, 1, 0, 3'b001, 32'h102, 32'h0, 1, 32'h80ADBEEF);
        check("lh_rdata", lsu_rdata, 32'hFFFF80AD);
        cyc(0, 1, 0, 3'b101, 32'h102, 32'h0, 0, 32'h0);
        cyc(0, 1, 0, 3'b101, 32'h102, 32'h0, 0, 32'h0);
        cyc(0, 1, 0, 3'b101, 32'h102, 32'h0, 1, 32'h80ADBEEF);
        check("lhu_rdata", lsu_rdata, 32'h000080AD);

        // SH 0x1234 @0x102: half replicated, upper lanes enabled
        cyc(0, 1, 1, 3'b001, 32'h102, 32'hFFFF1234, 0, 32'h0);
        cyc(0, 1, 1, 3'b001, 32'h102, 32'hFFFF1234, 0, 32'h0);
        check("sh_be", bus_if.be, 4'b1100);
        check("sh_wdata", bus_if.wdata, 32'h12341234);
        cyc(0, 1, 1, 3'b001, 32'h102, 32'hFFFF1234, 1, 32'h0);
        cyc(0, 0, 0, 3'b000, 32'h0, 32'h0, 0, 32'h0);

        // Illegal: LH @0x101, size 011 @0x0, SW @0x2
        cyc(0, 1, 0, 3'b001, 32'h101, 32'h0, 0, 32'h0);
        check("ill_lh_flag", lsu_illegal, 1);
        check("ill_lh_stall", lsu_stall, 0);
        cyc(0, 0, 0, 3'b000, 32'h0, 32'h0, 0, 32'h0);
        check("ill_lh_req", bus_if.req, 0);
        check("ill_lh_pulse", lsu_illegal, 0);
        cyc(0, 1, 0, 3'b011, 32'h0, 32'h0, 0, 32'h0);
        check("ill_sz_flag", lsu_illegal, 1);
        check("ill_sz_stall", lsu_stall, 0);
        cyc(0, 0, 0, 3'b000, 32'h0, 32'h0, 0, 32'h0);
        check("ill_sz_req", bus_if.req, 0);
        cyc(0, 1, 1, 3'b010, 32'h2, 32'h0, 0, 32'h0);
        check("ill_sw_flag", lsu_illegal, 1);
        cyc(0, 0, 0, 3'b000, 32'h0, 32'h0, 0, 32'h0);
        check("ill_sw_req", bus_if.req, 0);

        // ack while IDLE is ignored
        cyc(0, 0, 0, 3'b000, 32'h0, 32'h0, 1, 32'h55555555);
        check("idle_ack_rdata", lsu_rdata, 0);
        check("idle_ack_stall", lsu_stall, 0);

        // Timeout: LW @0x200, no ack
        cyc(0, 1, 0, 3'b010, 32'h200, 32'h0, 0, 32'h12345678);
        check("to_c0_stall", lsu_stall, 1);
        cyc(0, 1, 0, 3'b010, 32'h200, 32'h0, 0, 32'h12345678);
        check("to_c1_req", bus_if.req, 1);
        for (int k = 2; k <= 15; k++) begin
            cyc(0, 1, 0, 3'b010, 32'h200, 32'h0, 0, 32'h12345678);
            check("to_wait_req", bus_if.req, 0);
            check("to_wait_stall", lsu_stall, 1);
            check("to_wait_flag", lsu_timeout, 0);
        end
        cyc(0, 1, 0, 3'b010, 32'h200, 32'h0, 0, 32'h12345678);
        check("to_c16_flag", lsu_timeout, 1);
        check("to_c16_stall", lsu_stall, 0);
        check("to_c16_rdata", lsu_rdata, 0);
        cyc(0, 0, 0, 3'b000, 32'h0, 32'h0, 0, 32'h0);
        check("to_pulse", lsu_timeout, 0);

        // Next request after a timeout proceeds normally
        cyc(0, 1, 0, 3'b010, 32'h204, 32'h0, 0, 32'h0);
        check("post_to_stall", lsu_stall, 1);
        cyc(0, 1, 0, 3'b010, 32'h204, 32'h0, 0, 32'h0);
        check("post_to_req", bus_if.req, 1);
        check("post_to_addr", bus_if.addr, 32'h204);
        cyc(0, 1, 0, 3'b010, 32'h204, 32'h0, 1, 32'hCAFEF00D);
        check("post_to_rdata", lsu_rdata, 32'hCAFEF00D);
        cyc(0, 0, 0, 3'b000, 32'h0, 32'h0, 0, 32'h0);

        // Reset in the first WAIT cycle, late ack afterwards
        cyc(0, 1, 0, 3'b010, 32'h300, 32'h0, 0, 32'h0);
        check("rw_c0_stall", lsu_stall, 1);
        cyc(1, 1, 0, 3'b010, 32'h300, 32'h0, 0, 32'h0);
        check("rw_c1_stall", lsu_stall, 0);
        cyc(0, 0, 0, 3'b000, 32'h0, 32'h0, 1, 32'hA5A5A5A5);
        check("rw_c2_req", bus_if.req, 0);
        check("rw_c2_rdata", lsu_rdata, 0);
        check("rw_c2_stall", lsu_stall, 0);
        check("rw_c2_timeout", lsu_timeout, 0);
        cyc(0, 0, 0, 3'b000, 32'h0, 32'h0, 0, 32'h0);

        // Back-to-back: LW @0x4 then SW @0x8 with request held high
        cyc(0, 1, 0, 3'b010, 32'h4, 32'h0, 0, 32'h0);
        cyc(0, 1, 0, 3'b010, 32'h4, 32'h0, 0, 32'h0);
        check("b2b_c1_req", bus_if.req, 1);
        check("b2b_c1_addr", bus_if.addr, 32'h4);
        cyc(0, 1, 0, 3'b010, 32'h4, 32'h0, 1, 32'h11223344);
        check("b2b_c2_rdata", lsu_rdata, 32'h11223344);
        check("b2b_c2_stall", lsu_stall, 0);
        cyc(0, 1, 1, 3'b010, 32'h8, 32'h55667788, 0, 32'h0);
        check("b2b_c3_req", bus_if.req, 0);
        check("b2b_c3_stall", lsu_stall, 1);
        cyc(0, 1, 1, 3'b010, 32'h8, 32'h55667788, 0, 32'h0);
        check("b2b_c4_req", bus_if.req, 1);
        check("b2b_c4_addr", bus_if.addr, 32'h8);
        check("b2b_c4_we", bus_if.we, 1);
        check("b2b_c4_wdata", bus_if.wdata, 32'h55667788);
        for (int k = 5; k <= 18; k++) begin
            cyc(0, 1, 1, 3'b010, 32'h8, 32'h55667788, 0, 32'h0);
            check("b2b_wait_stall", lsu_stall, 1);
        end
        // ack arrives exactly on the timeout cycle: normal completion
        cyc(0, 1, 1, 3'b010, 32'h8, 32'h55667788, 1, 32'h0);
        check("b2b_ackto_timeout", lsu_timeout, 0);
        check("b2b_ackto_stall", lsu_stall, 0);
        check("b2b_ackto_rdata", lsu_rdata, 0);
        cyc(0, 0, 0, 3'b000, 32'h0, 32'h0, 0, 32'h0);
        check("b2b_end_timeout", lsu_timeout, 0);
        check("b2b_end_stall", lsu_stall, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
